// File: rtl/cpu_pkg.sv
// Shared fetch-unit types and defaults: FSM state enum, default parameters and
// the PC step derived from instruction width.
package cpu_pkg;

   localparam int unsigned XLEN_DEFAULT  = 32;
   localparam int unsigned ILEN_DEFAULT  = 32;
   localparam int unsigned DEPTH_DEFAULT = 4;
   localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;

   typedef enum logic {
      StRun,
      StDrain
   } fetch_state_e;

   // Bytes the PC advances per fetched instruction.
   function automatic int unsigned pc_incr(input int unsigned ilen);
      return ilen / 8;
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch queue: entries are reserved at request time, filled in order as
// responses arrive, and popped from the head once filled.
module fetch_queue
   import cpu_pkg::*;
#(
   parameter int unsigned XLEN  = XLEN_DEFAULT,
   parameter int unsigned ILEN  = ILEN_DEFAULT,
   parameter int unsigned DEPTH = DEPTH_DEFAULT,
   localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            alloc,
   input  logic [XLEN-1:0] alloc_pc,
   input  logic            fill,
   input  logic [ILEN-1:0] fill_instr,
   input  logic            pop,
   input  logic            flush,
   output logic            head_valid,
   output logic [XLEN-1:0] head_pc,
   output logic [ILEN-1:0] head_instr,
   output logic [CW-1:0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [XLEN-1:0]  pc_q    [DEPTH];
   logic [ILEN-1:0]  instr_q [DEPTH];
   logic [DEPTH-1:0] filled_q;
   logic [PW-1:0]    head_q, tail_q, fill_q;
   logic [CW-1:0]    count_q;

   // Fill always targets the oldest unfilled entry, so it can never collide
   // with the head being popped (filled) or the tail being reserved.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q   <= '0;
         tail_q   <= '0;
         fill_q   <= '0;
         count_q  <= '0;
         filled_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            pc_q[i]    <= '0;
            instr_q[i] <= '0;
         end
      end else if (flush) begin
         head_q   <= '0;
         tail_q   <= '0;
         fill_q   <= '0;
         count_q  <= '0;
         filled_q <= '0;
      end else begin
         if (alloc) begin
            pc_q[tail_q]     <= alloc_pc;
            filled_q[tail_q] <= 1'b0;
            tail_q           <= tail_q + PW'(1);
         end
         if (fill) begin
            instr_q[fill_q]  <= fill_instr;
            filled_q[fill_q] <= 1'b1;
            fill_q           <= fill_q + PW'(1);
         end
         if (pop) begin
            filled_q[head_q] <= 1'b0;
            head_q           <= head_q + PW'(1);
         end
         count_q <= count_q + CW'(alloc) - CW'(pop);
      end
   end

   assign head_valid = filled_q[head_q];
   assign head_pc    = pc_q[head_q];
   assign head_instr = instr_q[head_q];
   assign count      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC generation, request credits, redirect flush and
// stale-response draining in front of an in-order fetch queue.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int unsigned      XLEN     = XLEN_DEFAULT,
   parameter int unsigned      ILEN     = ILEN_DEFAULT,
   parameter int unsigned      DEPTH    = DEPTH_DEFAULT,
   parameter logic [XLEN-1:0]  RESET_PC = RESET_PC_DEFAULT[XLEN-1:0]
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [ILEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            dec_valid,
   input  logic            dec_ready,
   output logic [ILEN-1:0] dec_instr,
   output logic [XLEN-1:0] dec_pc
);

   localparam int unsigned     CW   = $clog2(DEPTH + 1);
   localparam logic [XLEN-1:0] INCR = XLEN'(pc_incr(ILEN));

   fetch_state_e    state_q;
   logic [XLEN-1:0] pc_q;
   logic [CW-1:0]   inflight_q, inflight_d;
   logic [CW-1:0]   drop_q;
   logic [CW-1:0]   q_count;
   logic            req_fire, dec_fire, rsp_accept;

   // In RUN every in-flight request already holds a reserved queue entry, so
   // occupancy alone bounds entries plus outstanding requests.
   assign imem_req_valid = !reset && (state_q == StRun) && !redirect_valid &&
                           (q_count < CW'(DEPTH));
   assign imem_req_addr  = pc_q;

   assign req_fire   = imem_req_valid && imem_req_ready;
   assign dec_fire   = dec_valid && dec_ready;
   assign rsp_accept = imem_rsp_valid && (drop_q == '0);
   assign inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StRun;
         pc_q       <= RESET_PC;
         inflight_q <= '0;
         drop_q     <= '0;
      end else begin
         inflight_q <= inflight_d;
         if (redirect_valid) begin
            // No request can fire this cycle, so inflight_d is the stale count.
            pc_q    <= redirect_pc;
            drop_q  <= inflight_d;
            state_q <= (inflight_d != '0) ? StDrain : StRun;
         end else begin
            unique case (state_q)
               StRun: begin
                  if (req_fire) pc_q <= pc_q + INCR;
               end
               StDrain: begin
                  if (imem_rsp_valid) begin
                     drop_q <= drop_q - CW'(1);
                     if (drop_q == CW'(1)) state_q <= StRun;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   fetch_queue #(
      .XLEN  (XLEN),
      .ILEN  (ILEN),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk        (clk),
      .reset      (reset),
      .alloc      (req_fire),
      .alloc_pc   (pc_q),
      .fill       (rsp_accept),
      .fill_instr (imem_rsp_data),
      .pop        (dec_fire),
      .flush      (redirect_valid),
      .head_valid (dec_valid),
      .head_pc    (dec_pc),
      .head_instr (dec_instr),
      .count      (q_count)
   );

   rsp_in_flight_a : assert property (@(posedge clk) disable iff (reset)
      imem_rsp_valid |-> (inflight_q != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised and directed bench for fetch_unit against a queue-level model; a
// second instance with RESET_PC near the top of memory checks PC wrap-around.
module tb_fetch_unit;

   localparam int DEPTH = 4;
   localparam int LOGN  = 8192;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req_ready = 1'b0, imem_rsp_valid = 1'b0;
   logic        redirect_valid = 1'b0, dec_ready = 1'b0;
   logic [31:0] imem_rsp_data = '0, redirect_pc = '0;

   logic        a_req_valid, a_dec_valid, b_req_valid, b_dec_valid;
   logic [31:0] a_req_addr, a_dec_instr, a_dec_pc;
   logic [31:0] b_req_addr, b_dec_instr, b_dec_pc;

   always #5 clk = ~clk;

   fetch_unit #(.XLEN(32), .ILEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut_a (
      .clk(clk), .reset(reset),
      .imem_req_valid(a_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(a_req_addr), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .dec_valid(a_dec_valid), .dec_ready(dec_ready),
      .dec_instr(a_dec_instr), .dec_pc(a_dec_pc)
   );

   fetch_unit #(.XLEN(32), .ILEN(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC)) dut_b (
      .clk(clk), .reset(reset),
      .imem_req_valid(b_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(b_req_addr), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .dec_valid(b_dec_valid), .dec_ready(dec_ready),
      .dec_instr(b_dec_instr), .dec_pc(b_dec_pc)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      bit          filled;
   } ent_t;

   typedef struct {
      logic [31:0] data;
      int          due;
   } rsp_t;

   ent_t        mq[$];    // model fetch queue
   rsp_t        mem[$];   // outstanding requests in the memory, oldest first
   logic [31:0] m_pc;
   logic [31:0] off;      // dut_b PC offset until the first redirect
   int          cyc = 0;
   int          last_due = -1;
   int          n_vec = 0, n_err = 0;

   int          p_ready, p_dec, p_redir, lat_min, lat_max;
   bit          force_redir = 1'b0;
   logic [31:0] force_pc = '0;

   logic        lg_req_v [LOGN];
   logic [31:0] lg_addr  [LOGN];
   logic        lg_dv    [LOGN];
   logic [31:0] lg_dpc   [LOGN];
   logic [31:0] lg_dpc_b [LOGN];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      redirect_valid = 1'b0;
      dec_ready      = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("rst_req_valid", {31'b0, a_req_valid}, 32'd0);
      chk("rst_dec_valid", {31'b0, a_dec_valid}, 32'd0);
      chk("rst_dec_instr", a_dec_instr, 32'd0);
      chk("rst_dec_pc",    a_dec_pc,    32'd0);
      chk("rst_req_addr",  a_req_addr,  32'h0000_0000);
      chk("rst_b_req_valid", {31'b0, b_req_valid}, 32'd0);
      chk("rst_b_dec_pc",  b_dec_pc,    32'd0);
      chk("rst_b_req_addr", b_req_addr, 32'hFFFF_FFFC);
      mq.delete();
      mem.delete();
      m_pc     = 32'h0;
      off      = 32'hFFFF_FFFC;
      last_due = -1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("post_rst_req_valid", {31'b0, a_req_valid}, 32'd1);
      chk("post_rst_req_addr", a_req_addr, 32'h0);
   endtask

   // One clock: drive random inputs, compare every output with the model, advance the model.
   task automatic step();
      bit          rv, ev, dv, rf, df, done;
      logic [31:0] r;
      ent_t        e;
      rsp_t        m;
      int          due;
      @(negedge clk);
      rv = (mem.size() > 0) && (mem[0].due <= cyc);
      imem_rsp_valid = rv;
      imem_rsp_data  = rv ? mem[0].data : $urandom;
      if (force_redir) begin
         redirect_valid = 1'b1;
         redirect_pc    = force_pc;
         force_redir    = 1'b0;
      end else begin
         redirect_valid = ($urandom_range(99) < p_redir);
         r              = $urandom;
         redirect_pc    = r & 32'hFFFF_FFFC;
      end
      imem_req_ready = ($urandom_range(99) < p_ready);
      dec_ready      = ($urandom_range(99) < p_dec);
      #1;
      ev = (mem.size() == 0 || !(mq.size() == 0 && mem.size() > 0)) &&
           !redirect_valid && (mq.size() < DEPTH);
      // Draining whenever outstanding responses have no queue entry to land in.
      ev = ev && (mem.size() <= mq.size());
      dv = (mq.size() > 0) && mq[0].filled;
      chk("req_valid", {31'b0, a_req_valid}, {31'b0, ev});
      chk("req_addr", a_req_addr, m_pc);
      chk("dec_valid", {31'b0, a_dec_valid}, {31'b0, dv});
      chk("b_req_valid", {31'b0, b_req_valid}, {31'b0, ev});
      chk("b_req_addr", b_req_addr, m_pc + off);
      chk("b_dec_valid", {31'b0, b_dec_valid}, {31'b0, dv});
      if (dv) begin
         chk("dec_pc", a_dec_pc, mq[0].pc);
         chk("dec_instr", a_dec_instr, mq[0].instr);
         chk("b_dec_pc", b_dec_pc, mq[0].pc + off);
         chk("b_dec_instr", b_dec_instr, mq[0].instr);
      end
      if (cyc < LOGN) begin
         lg_req_v[cyc] = a_req_valid;
         lg_addr[cyc]  = a_req_addr;
         lg_dv[cyc]    = a_dec_valid;
         lg_dpc[cyc]   = a_dec_pc;
         lg_dpc_b[cyc] = b_dec_pc;
      end
      rf = ev && imem_req_ready;
      df = dv && dec_ready;
      // Responses with no unfilled queue entry are stale and vanish.
      if (rv) begin
         if (mem.size() <= mq.size() || mem.size() == 0) begin
            done = 1'b0;
            for (int i = 0; i < mq.size(); i++) begin
               if (!done && !mq[i].filled) begin
                  e        = mq[i];
                  e.filled = 1'b1;
                  e.instr  = imem_rsp_data;
                  mq[i]    = e;
                  done     = 1'b1;
               end
            end
         end
         void'(mem.pop_front());
      end
      if (df) void'(mq.pop_front());
      if (rf) begin
         e.pc = m_pc; e.instr = '0; e.filled = 1'b0;
         mq.push_back(e);
         due = cyc + $urandom_range(lat_max, lat_min);
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         m.data = $urandom;
         m.due  = due;
         mem.push_back(m);
      end
      if (redirect_valid) begin
         mq.delete();
         m_pc = redirect_pc;
         off  = 32'h0;
      end else if (rf) begin
         m_pc = m_pc + 32'd4;
      end
      cyc++;
      @(posedge clk);
   endtask

   task automatic knobs(input int rdy, input int dec, input int rdr, input int lmin,
                        input int lmax);
      p_ready = rdy; p_dec = dec; p_redir = rdr; lat_min = lmin; lat_max = lmax;
   endtask

   initial begin
      int s, n;
      // Streaming from reset, with wrap-around on dut_b.
      do_reset();
      knobs(100, 100, 0, 1, 1);
      s = cyc;
      for (int k = 0; k < 12; k++) step();
      chk("stream_startup_dv0", {31'b0, lg_dv[s]},   32'd0);
      chk("stream_startup_dv1", {31'b0, lg_dv[s+1]}, 32'd0);
      for (int k = 2; k < 12; k++) begin
         chk("stream_dv", {31'b0, lg_dv[s+k]}, 32'd1);
         chk("stream_pc", lg_dpc[s+k], 32'(4 * (k - 2)));
      end
      chk("wrap_pc0", lg_dpc_b[s+2], 32'hFFFF_FFFC);
      chk("wrap_pc1", lg_dpc_b[s+3], 32'h0000_0000);

      // Redirect in the same cycle the decoder takes PC 0x8.
      do_reset();
      s = cyc;
      for (int k = 0; k < 4; k++) step();
      force_redir = 1'b1; force_pc = 32'h200;
      for (int k = 0; k < 6; k++) step();
      chk("coinc_pc8", lg_dpc[s+4], 32'h8);
      chk("coinc_pc4", lg_dpc[s+3], 32'h4);
      chk("coinc_gap5", {31'b0, lg_dv[s+5]}, 32'd0);
      chk("coinc_gap6", {31'b0, lg_dv[s+6]}, 32'd0);
      chk("coinc_next_dv", {31'b0, lg_dv[s+7]}, 32'd1);
      chk("coinc_next_pc", lg_dpc[s+7], 32'h200);

      // Redirect with three requests in flight; all three responses are stale.
      do_reset();
      knobs(100, 100, 0, 5, 5);
      s = cyc;
      for (int k = 0; k < 3; k++) step();
      force_redir = 1'b1; force_pc = 32'h100;
      for (int k = 0; k < 13; k++) step();
      for (int k = 3; k < 8; k++) chk("drain_no_req", {31'b0, lg_req_v[s+k]}, 32'd0);
      chk("drain_exit_req", {31'b0, lg_req_v[s+8]}, 32'd1);
      chk("drain_exit_addr", lg_addr[s+8], 32'h100);
      for (int k = 0; k < 14; k++) chk("drain_no_dv", {31'b0, lg_dv[s+k]}, 32'd0);
      chk("drain_next_dv", {31'b0, lg_dv[s+14]}, 32'd1);
      chk("drain_next_pc", lg_dpc[s+14], 32'h100);

      // Decoder stalled for ten cycles: queue fills to DEPTH and holds.
      do_reset();
      knobs(100, 0, 0, 1, 1);
      s = cyc;
      for (int k = 0; k < 10; k++) step();
      n = 0;
      for (int k = 0; k < 10; k++) n += int'(lg_req_v[s+k]);
      chk("bp_req_count", 32'(n), 32'd4);
      chk("bp_req_low", {31'b0, lg_req_v[s+9]}, 32'd0);
      knobs(100, 100, 0, 1, 1);
      for (int k = 0; k < 8; k++) step();
      for (int k = 0; k < 5; k++) begin
         chk("bp_release_dv", {31'b0, lg_dv[s+10+k]}, 32'd1);
         chk("bp_release_pc", lg_dpc[s+10+k], 32'(4 * k));
      end

      // Reset while draining stale responses.
      do_reset();
      knobs(100, 100, 0, 5, 5);
      for (int k = 0; k < 3; k++) step();
      force_redir = 1'b1; force_pc = 32'h300;
      step();
      step();
      do_reset();
      knobs(100, 100, 0, 1, 1);
      s = cyc;
      step();
      chk("rst_drain_req", {31'b0, lg_req_v[s]}, 32'd1);
      chk("rst_drain_addr", lg_addr[s], 32'h0);

      // Randomised traffic.
      do_reset();
      knobs(75, 65, 5, 1, 4);
      for (int k = 0; k < 1500; k++) step();
      do_reset();
      knobs(90, 20, 3, 1, 3);
      for (int k = 0; k < 600; k++) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: PC and instruction-address width.
REQ-002 SHALL have parameter ILEN, default 32: instruction width, a multiple of 8; PC increment is ILEN/8.
REQ-003 SHALL have parameter DEPTH, default 4: fetch-queue entries and the maximum number of in-flight requests; power of two, at least 2.
REQ-004 SHALL have parameter RESET_PC, default 0: PC value after reset.
REQ-005 SHALL have one clock; reset is asynchronous and active-high; the ports are named clk and reset.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  async active-high reset.
REQ-008 imem_req_valid  output  1  fetch request valid.
REQ-009 imem_req_ready  input  1  memory accepts the request.
REQ-010 imem_req_addr  output  XLEN  fetch address.
REQ-011 imem_rsp_valid  input  1  instruction returned; in order; latency of at least 1 cycle; never back-pressured.
REQ-012 imem_rsp_data  input  ILEN  returned instruction.
REQ-013 redirect_valid  input  1  one-cycle pulse: branch, jump or exception redirect.
REQ-014 redirect_pc  input  XLEN  new fetch PC.
REQ-015 dec_valid  output  1  head entry holds a valid instruction.
REQ-016 dec_ready  input  1  decoder accepts the head entry.
REQ-017 dec_instr  output  ILEN  head instruction.
REQ-018 dec_pc  output  XLEN  PC of the head instruction.

Function
REQ-019 SHALL implement states RUN and DRAIN.
- Reset enters RUN.
- RUN moves to DRAIN on a redirect while drop_cnt is nonzero after update.
- DRAIN moves to RUN when drop_cnt reaches 0.
REQ-020 A request SHALL fire when imem_req_valid and imem_req_ready are both high; a decode transfer SHALL fire when dec_valid and dec_ready are both high.
REQ-021 imem_req_valid SHALL be high only when all of the following hold:
- state is RUN;
- redirect_valid is low;
- queue entries plus in-flight requests are fewer than DEPTH.
REQ-022 imem_req_addr SHALL equal the PC register; on each request fire, the PC SHALL advance by ILEN/8, modulo 2^XLEN.
REQ-023 On request fire, the unit SHALL reserve the tail queue entry with PC = imem_req_addr and the entry marked not-filled.
REQ-024 On an accepted response (imem_rsp_valid high and drop_cnt = 0), the unit SHALL write imem_rsp_data into the oldest not-filled entry and mark it filled.
REQ-025 dec_valid SHALL equal the filled flag of the head entry; dec_instr and dec_pc SHALL be driven from the head entry.
REQ-026 A request fire, a response write and a decode transfer in the same cycle SHALL all take effect with no loss of entries or credits.
REQ-027 On redirect_valid, the unit SHALL take these actions in the same cycle:
- PC <= redirect_pc;
- every queue entry is invalidated, whether filled or not;
- drop_cnt <= in-flight count minus 1 if a response arrives that cycle, else the in-flight count.
REQ-028 While drop_cnt > 0, each imem_rsp_valid SHALL be discarded and SHALL decrement drop_cnt; no request SHALL issue in DRAIN.
REQ-029 If a decode transfer fires in the same cycle as redirect_valid, that transfer SHALL count as completed and the flush SHALL apply to the remaining entries.
REQ-030 A redirect in DRAIN SHALL recompute drop_cnt per REQ-027 and remain in DRAIN or exit to RUN accordingly.
REQ-031 Queue pointers SHALL wrap modulo DEPTH; full/empty SHALL be distinguished by an occupancy counter of width $clog2(DEPTH+1).
REQ-032 A response arriving while no request is in flight is illegal and SHALL fire a simulation assertion.

Reset
REQ-033 Reset SHALL set the following values:
- PC = RESET_PC;
- state = RUN;
- queue empty;
- in-flight count = 0;
- drop_cnt = 0.
REQ-034 During reset, outputs SHALL be imem_req_valid = 0, dec_valid = 0, dec_instr = 0 and dec_pc = 0; imem_req_addr SHALL show RESET_PC.
REQ-035 Reset asserted mid-operation SHALL abandon all in-flight responses; on the first cycle after reset deassertion, imem_req_valid SHALL rise if the REQ-021 conditions hold.

Structure
REQ-036 The state enum, PC increment constant and default parameter values SHALL live in the shared package cpu_pkg.
REQ-037 The queue SHALL be one sub-module, fetch_queue: DEPTH entries of {pc, instr, filled}, with alloc, fill, pop and flush ports.
REQ-038 PC logic, the credit counter, drop_cnt and the FSM SHALL live in fetch_unit.

Verification
REQ-039 Streaming: ready=1, response latency 1, dec_ready=1 -> dec_pc sequence 0x0, 0x4, 0x8, ... with one instruction per cycle after a 2-cycle startup.
REQ-040 Back-pressure: dec_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests issued, imem_req_valid low afterwards, no instruction lost after release.
REQ-041 Redirect with 3 in flight, redirect_pc=0x100 -> the 3 stale responses are dropped and the next dec_pc is 0x100.
REQ-042 Redirect coincident with a decode transfer of PC 0x8 -> 0x8 is consumed once and the next dec_pc is redirect_pc.
REQ-043 Wrap-around: RESET_PC = 2^XLEN-4 -> dec_pc sequence FFFFFFFC, then 00000000.
REQ-044 Reset asserted mid-DRAIN -> outputs reach their reset values immediately; after deassertion, the first request addresses RESET_PC.
